// File: rtl/mult_div_unit_pkg.sv
// Purpose: shared constants for the multiply/divide unit: op codes, latencies,
//          FSM state encoding and a sign/magnitude helper.
// Ports:   none (package).
package mult_div_unit_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 5;

    // md op codes driven by the decoder; any other code is a no-op
    localparam logic [OP_W-1:0] mdMult  = 3'd0;
    localparam logic [OP_W-1:0] mdMultu = 3'd1;
    localparam logic [OP_W-1:0] mdDiv   = 3'd2;
    localparam logic [OP_W-1:0] mdDivu  = 3'd3;
    localparam logic [OP_W-1:0] mdMthi  = 3'd4;
    localparam logic [OP_W-1:0] mdMtlo  = 3'd5;

    // Busy time in cycles, measured from the accept edge
    localparam int unsigned mdMulCycles = 5;
    localparam int unsigned mdDivCycles = 33;

    // MUL runs counter down to 0 then writes: mdMulCycles-1 loads.
    // DIV does one step per count down to 0, then one FIX cycle.
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(mdMulCycles - 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(mdDivCycles - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    // Absolute value when treated as signed, raw value otherwise
    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                  input logic            is_signed);
        return (is_signed && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_div_step.sv
// Purpose: one combinational restoring radix-2 divide step, MSB first.
//          The quotient register starts holding the dividend; each step shifts
//          one dividend bit into the remainder and one quotient bit in at LSB.
// Ports:   rem/quo/divisor in (current state), next_rem/next_quo out.
module mult_div_unit_div_step
    import mult_div_unit_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic [XLEN-1:0] next_quo
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;
    logic          fits;

    assign shifted  = {rem, quo[XLEN-1]};
    assign diff     = shifted - {1'b0, divisor};
    // rem < divisor keeps diff below 2^XLEN on success, so bit XLEN is the borrow
    assign fits     = ~diff[XLEN];
    assign next_rem = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign next_quo = {quo[XLEN-2:0], fits};

endmodule

// File: rtl/mult_div_unit.sv
// Purpose: multi-cycle multiply/divide unit with HI/LO registers for the
//          E stage of the MIPS pipeline.
// Ports:   clk, reset (async, active-high)
//          start, op[2:0], operandA[31:0], operandB[31:0]  E-stage md request
//          dMdAccess                                        D-stage md/MFHI/MFLO
//          busy (registered), stall (combinational), hi/lo[31:0] (registered)
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] operandA,
    input  logic [XLEN-1:0] operandB,
    input  logic            dMdAccess,
    output logic            busy,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    md_state_t         state;
    logic [CNT_W-1:0]  counter;
    logic [2*XLEN-1:0] product;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   divisor;
    logic              q_neg;
    logic              r_neg;

    logic [XLEN-1:0]   step_rem;
    logic [XLEN-1:0]   step_quo;
    logic              div_signed;
    logic [XLEN-1:0]   quo_fixed;
    logic [XLEN-1:0]   rem_fixed;

    // Hold the D-stage md instruction while an md op is in E or still running
    assign stall = dMdAccess && (busy || start);

    assign div_signed = (op == mdDiv);
    assign quo_fixed  = q_neg ? -quo : quo;
    assign rem_fixed  = r_neg ? -rem : rem;

    mult_div_unit_div_step u_div_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .next_rem (step_rem),
        .next_quo (step_quo)
    );

    // Control FSM plus HI/LO and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            counter <= '0;
            product <= '0;
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (op)
                            mdMult: begin
                                product <= {{XLEN{operandA[XLEN-1]}}, operandA} *
                                           {{XLEN{operandB[XLEN-1]}}, operandB};
                                counter <= MUL_CNT_INIT;
                                state   <= ST_MUL;
                                busy    <= 1'b1;
                            end
                            mdMultu: begin
                                product <= {{XLEN{1'b0}}, operandA} * {{XLEN{1'b0}}, operandB};
                                counter <= MUL_CNT_INIT;
                                state   <= ST_MUL;
                                busy    <= 1'b1;
                            end
                            mdDiv, mdDivu: begin
                                quo     <= magnitude(operandA, div_signed);
                                divisor <= magnitude(operandB, div_signed);
                                rem     <= '0;
                                q_neg   <= div_signed && (operandA[XLEN-1] ^ operandB[XLEN-1]);
                                r_neg   <= div_signed && operandA[XLEN-1];
                                counter <= DIV_CNT_INIT;
                                state   <= ST_DIV;
                                busy    <= 1'b1;
                            end
                            mdMthi:  hi <= operandA;
                            mdMtlo:  lo <= operandA;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (counter == '0) begin
                        hi    <= product[2*XLEN-1:XLEN];
                        lo    <= product[XLEN-1:0];
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ST_DIV: begin
                    rem <= step_rem;
                    quo <= step_quo;
                    if (counter == '0) begin
                        state <= ST_FIX;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ST_FIX: begin
                    // With a zero divisor every step "fits", so the remainder
                    // magnitude ends as |dividend| and rem_fixed restores the
                    // dividend as given; only the quotient needs overriding.
                    hi    <= rem_fixed;
                    lo    <= (divisor == '0) ? '1 : quo_fixed;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose: self-checking scoreboard bench for mult_div_unit.
// Ports:   none (top-level testbench).
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        dMdAccess;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] sb_q[$];

    int          n;
    int          stall_hi;
    logic [63:0] e;
    logic [31:0] ra;
    logic [31:0] rb;

    localparam logic [2:0] OP_NONE = 3'd7;

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .dMdAccess (dMdAccess),
        .busy      (busy),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, measure busy time, then compare against the scoreboard entry
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input int e_busy, input bit b2b);
        int cnt;
        logic [63:0] exp;
        if (!b2b) @(negedge clk);
        start    = 1'b1;
        op       = o;
        operandA = a;
        operandB = b;
        sb_q.push_back({e_hi, e_lo});
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        cnt   = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check_val({tag, "_busy"}, 64'(cnt), 64'(e_busy));
        exp = sb_q.pop_front();
        check_val({tag, "_hi"}, 64'(hi), 64'(exp[63:32]));
        check_val({tag, "_lo"}, 64'(lo), 64'(exp[31:0]));
        model_hi = exp[63:32];
        model_lo = exp[31:0];
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        int q;
        int r;
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
    endfunction

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        op        = 3'd0;
        operandA  = '0;
        operandB  = '0;
        dMdAccess = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_hi", 64'(hi), 64'd0);
        check_val("rst_lo", 64'(lo), 64'd0);
        dMdAccess = 1'b1;
        #1 check_val("rst_stall_idle", 64'(stall), 64'd0);
        start = 1'b1;
        #1 check_val("rst_stall_start", 64'(stall), 64'd1);
        start     = 1'b0;
        dMdAccess = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        run_op("mult_neg", mdMult, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, 1'b0);
        run_op("multu", mdMultu, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
        // Same cycle busy falls: the next start must be accepted
        run_op("mult_b2b", mdMult, 32'd7, 32'd6, 32'd0, 32'd42, 5, 1'b1);
        run_op("div_neg", mdDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("divu_big", mdDivu, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 33, 1'b0);
        run_op("divu_zero", mdDivu, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("div_ovf", mdDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33, 1'b0);
        run_op("div_zero", mdDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 33, 1'b0);
        run_op("mtlo", mdMtlo, 32'hCAFE_F00D, 32'd0, model_hi, 32'hCAFE_F00D, 0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom;
            e  = smul(ra, rb);
            run_op("mult_rnd", mdMult, ra, rb, e[63:32], e[31:0], 5, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 65535);
            run_op("divu_rnd", mdDivu, ra, rb, ra % rb, ra / rb, 33, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            ra = $urandom;
            rb = 32'($urandom_range(2, 5000));
            if (i[0]) rb = -rb;
            e  = sdiv(ra, rb);
            run_op("div_rnd", mdDiv, ra, rb, e[63:32], e[31:0], 33, 1'b0);
        end

        // Divide with the D-stage access held and a stray start while busy
        dMdAccess = 1'b1;
        @(negedge clk);
        start    = 1'b1;
        op       = mdDiv;
        operandA = 32'hFFFF_FFEC;
        operandB = 32'd3;
        sb_q.push_back({32'hFFFF_FFFE, 32'hFFFF_FFFA});
        #1 check_val("stall_accept", 64'(stall), 64'd1);
        @(negedge clk);
        start    = 1'b0;
        op       = OP_NONE;
        n        = 0;
        stall_hi = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (stall) stall_hi++;
            if (n == 5) begin
                start    = 1'b1;
                op       = mdMthi;
                operandA = 32'hDEAD_BEEF;
            end
            if (n == 6) begin
                start = 1'b0;
                op    = OP_NONE;
                check_val("busy_start_hi", 64'(hi), 64'(model_hi));
                check_val("busy_start_lo", 64'(lo), 64'(model_lo));
            end
            @(negedge clk);
        end
        check_val("stall_div_busy", 64'(n), 64'd33);
        check_val("stall_div_cycles", 64'(stall_hi), 64'd33);
        check_val("stall_release", 64'(stall), 64'd0);
        e = sb_q.pop_front();
        check_val("stall_div_hi", 64'(hi), 64'(e[63:32]));
        check_val("stall_div_lo", 64'(lo), 64'(e[31:0]));
        model_hi  = e[63:32];
        model_lo  = e[31:0];
        dMdAccess = 1'b0;

        // Unused op code: nothing happens
        run_op("noop", 3'd6, 32'h1111_1111, 32'h2222_2222, model_hi, model_lo, 0, 1'b0);

        // Reset during a divide aborts and clears HI/LO
        @(negedge clk);
        start    = 1'b1;
        op       = mdDivu;
        operandA = 32'd1000;
        operandB = 32'd7;
        @(negedge clk);
        start = 1'b0;
        op    = OP_NONE;
        repeat (9) @(negedge clk);
        check_val("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_hi", 64'(hi), 64'd0);
        check_val("abort_lo", 64'(lo), 64'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;

        run_op("mthi", mdMthi, 32'h1234_5678, 32'd0, 32'h1234_5678, model_lo, 0, 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core. It sits beside the ALU in the E stage and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO. It runs multiply and divide over several cycles, reports `busy`, and raises `stall` so a later HI/LO-dependent instruction waits in D. Results appear on `hi`/`lo` for MFHI/MFLO forwarding.

## Interface
- No parameters; latencies are fixed constants (see Structure).
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `start`  in  1  E-stage instruction is an md operation this cycle; sampled only in IDLE.
- `op`  in  3  `mdMult`, `mdMultu`, `mdDiv`, `mdDivu`, `mdMthi`, `mdMtlo`; other codes are no-ops.
- `operandA`  in  32  rs value, forwarded.
- `operandB`  in  32  rt value, forwarded.
- `dMdAccess`  in  1  D-stage instruction is an md operation, MFHI or MFLO.
- `busy`  out  1  operation in progress.
- `stall`  out  1  `dMdAccess && (busy || start)`; combinational.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + `start`:
  - mult/multu: register the full 64-bit product (signed/unsigned per op), counter=4, go to MUL.
  - div/divu: latch operand magnitudes and result signs (signed only), clear partial remainder, counter=31, go to DIV.
  - mthi/mtlo: write `operandA` to HI/LO at this edge; stay IDLE; `busy` stays 0.
  - Other op: ignored.
- MUL: decrement the counter; at counter==0, write HI=product[63:32], LO=product[31:0], go to IDLE.
- DIV: one restoring radix-2 step per cycle, MSB first. At counter==0 go to FIX.
- FIX: apply signs (quotient negative iff operand signs differ; remainder takes the dividend's sign), write LO=quotient, HI=remainder, go to IDLE.
- Divide by zero, both signednesses: LO=0xFFFFFFFF, HI=dividend as given. Results are still written after the full 33 cycles.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- `start` outside IDLE is ignored. The pipeline guarantees this via `stall`, and the bench checks that the ignore is honoured.
- HI/LO never change except at the result-write edge or an mthi/mtlo edge.

## Timing
- Reset: state=IDLE, counter=0, `busy`=0, `hi`=0, `lo`=0, internal divider registers=0. `stall` follows its equation.
- `busy` is registered; it is 1 exactly when state≠IDLE.
- Accept edge is E0. Mult/multu: `busy`=1 for 5 cycles; HI/LO valid and `busy`=0 from E0+5.
- Div/divu: 32 DIV cycles plus 1 FIX cycle; HI/LO valid and `busy`=0 from E0+33.
- mthi/mtlo: new value visible the cycle after the edge, so there is zero busy time.
- The `stall` path is purely combinational, so the D instruction holds while an md op is in E or running.
- `start` in the same cycle that `busy` falls is accepted, because the state is IDLE by then.
- `reset` mid-operation aborts immediately. No partial result is written; HI/LO return to 0.

## Structure
- Shared `constants.v`: `mdMult`..`mdMtlo` op codes, `mdMulCycles`=5, `mdDivCycles`=33, and state encodings.
- Sub-module `div_step`: combinational restoring step. Inputs are partial remainder, quotient and divisor; outputs are the next remainder and next quotient. The parent iterates it.
- Multiply uses a single `*` into a product register; the counter only models latency.

## Test plan
- mult A=0xFFFFFFFD (-3), B=5 -> after 5 busy cycles: HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. Then an immediate `start` of a second op in the cycle `busy` falls -> accepted.
- div A=-7, B=2 -> `busy` for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. The same inputs via divu -> LO=0x7FFFFFFC, HI=0x00000001.
- divu A=100, B=0 -> LO=0xFFFFFFFF, HI=0x00000064. div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- `dMdAccess`=1 throughout a div -> `stall`=1 from the accept cycle through the FIX cycle, and 0 the cycle after. A `start` pulse while busy -> HI/LO unaffected.
- Reset asserted at DIV cycle 10 -> `busy`=0, HI=LO=0 immediately. Then mthi 0x12345678 -> `hi`=0x12345678 the next cycle, `busy` never rises.
